// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Purpose : Shared UART definitions: FSM state encoding and the bit-timing   |
// |           helpers used by both the receiver and the matching transmitter.  |
// | Ports   : none (package)                                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  // State encodings are kept as plain localparams so the transmitter can
  // reuse the same numbering without pulling in the receiver's enum.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP,
    S_WAIT_HIGH = ST_WAIT_HIGH
  } uart_state_e;

  // Clock cycles per serial symbol (integer division, truncating).
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Offset inside a symbol where the line is sampled (mid-symbol).
  function automatic int sample_time(input int symbol_cycles);
    return symbol_cycles / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +----------------------------------------------------------------------------+
// | Module  : sync_2ff                                                         |
// | Purpose : Two-flop synchronizer for a single asynchronous input bit.       |
// | Ports   : clk   - clock                                                    |
// |           rst_n - asynchronous active-low reset (flops load RESET_VALUE)   |
// |           d_i   - asynchronous input                                       |
// |           q_o   - synchronized output, 2 cycles of latency                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_core                                                     |
// | Purpose : 8N1 UART receiver with a one-byte holding register, glitch       |
// |           rejection on the start bit, framing-error and overrun pulses.    |
// | Ports   : clk            - clock, all state on rising edge                 |
// |           rst_n          - asynchronous active-low reset                   |
// |           serial_in      - asynchronous UART line, idle high               |
// |           data_out       - received byte                                   |
// |           data_out_valid - data_out holds an unconsumed byte               |
// |           data_out_ready - consumer accepts data_out this cycle            |
// |           frame_error    - 1-cycle pulse when the stop bit samples 0       |
// |           overrun        - 1-cycle pulse when a good byte is dropped       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_rx_core #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_error,
  output logic       overrun
);

  import uart_pkg::*;

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = sample_time(SYMBOL_EDGE_TIME);
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  // Below 4 cycles per symbol the mid-symbol sample and the symbol end
  // collide, so the timing scheme no longer holds.
  generate
    if (SYMBOL_EDGE_TIME < 4) begin : g_bad_rate
      $error("uart_rx_core: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  localparam logic [CNT_W-1:0] c_sample_cnt = CNT_W'(SAMPLE_TIME);
  localparam logic [CNT_W-1:0] c_last_cnt   = CNT_W'(SYMBOL_EDGE_TIME - 1);

  logic line_sync;

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (serial_in),
    .q_o   (line_sync)
  );

  uart_state_e      state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q,   shreg_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             ferr_q,    ferr_d;
  logic             ovr_q,     ovr_d;
  logic             byte_good;
  logic             at_sample;
  logic             at_last;

  assign at_sample = (cnt_q == c_sample_cnt);
  assign at_last   = (cnt_q == c_last_cnt);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_good = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!line_sync) state_d = S_START;
      end

      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (at_sample && line_sync) begin
          // Line back high mid start bit: treat as a glitch.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end

      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (at_sample) shreg_d = {line_sync, shreg_q[7:1]};  // LSB arrives first
        if (at_last) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end

      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (at_sample) begin
          // Leave at mid stop bit so a following start edge is caught
          // even with no idle time between frames.
          cnt_d = '0;
          if (line_sync) begin
            byte_good = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end

      S_WAIT_HIGH: begin
        // A break or stuck-low line reports one error, not one per frame time.
        cnt_d = '0;
        if (line_sync) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Holding register: a new byte may replace one being accepted this
    // cycle; otherwise an occupied register keeps its byte and the new one
    // is dropped.
    if (byte_good) begin
      if (!valid_q || data_out_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign frame_error    = ferr_q;
  assign overrun        = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx_core                                                  |
// | Purpose : Self-checking bench for uart_rx_core at 5 clock cycles per bit.  |
// |           Expected bytes are queued when a frame is sent and compared on   |
// |           each data_out handshake.                                         |
// | Ports   : none                                                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_core;

  import uart_pkg::*;

  localparam int CF      = 50_000_000;
  localparam int BR      = 10_000_000;
  localparam int BIT_CYC = 5;
  // Start edge driven just after edge P0: 2 sync flops + 1 detect cycle,
  // 5-cycle start bit, 8*5 data cycles, stop sample at count 2 (3 edges
  // into the stop state), valid registered on that edge -> P51.
  localparam int EXP_LATENCY = 51;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       frame_error;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] sb_q[$];
  int n_hs   = 0;
  int n_vcyc = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int rise_cyc = -1;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  uart_rx_core #(
    .CLOCK_FREQ (CF),
    .BAUD_RATE  (BR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_error    (frame_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor / scoreboard, sampling on the falling edge.
  initial forever begin
    logic [7:0] exp_b;
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (data_out_valid) n_vcyc++;
      if (frame_error) n_ferr++;
      if (overrun) n_ovr++;
      if (data_out_valid && !prev_valid) rise_cyc = cyc;
      if (prev_valid && !prev_ready && data_out_valid) begin
        checks++;
        if (data_out !== prev_data) begin
          errors++;
          $display("FAIL hold_stable: data_out=%h required %h", data_out, prev_data);
        end
      end
      if (data_out_valid && data_out_ready) begin
        n_hs++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: data_out=%h required none", data_out);
        end else begin
          exp_b = sb_q.pop_front();
          if (data_out !== exp_b) begin
            errors++;
            $display("FAIL rx_byte: data_out=%h required %h", data_out, exp_b);
          end
        end
      end
      prev_valid = data_out_valid;
      prev_ready = data_out_ready;
      prev_data  = data_out;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; leaves the line
  // at the stop level so frames can be chained without idle time.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_byte);
    if (expect_byte) sb_q.push_back(b);
    serial_in = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      wait_cyc(BIT_CYC);
    end
    serial_in = stop_bit;
    wait_cyc(BIT_CYC);
  endtask

  task automatic test_reset();
    rst_n          = 1'b1;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", data_out); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", data_out_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b required 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b required 0", overrun); end
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b required 0", data_out_valid); end
  endtask

  task automatic test_single();
    int t0, v0, f0, o0, h0;
    data_out_ready = 1'b1;
    v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr; h0 = n_hs;
    rise_cyc = -1;
    t0 = cyc;
    send_frame(8'h61, 1'b1, 1'b1);
    wait_cyc(10);
    checks++; if (n_hs - h0 !== 1) begin errors++; $display("FAIL single_count: got %0d bytes required 1", n_hs - h0); end
    checks++; if (rise_cyc - t0 !== EXP_LATENCY) begin errors++; $display("FAIL single_latency: got %0d cycles required %0d", rise_cyc - t0, EXP_LATENCY); end
    checks++; if (n_vcyc - v0 !== 1) begin errors++; $display("FAIL single_valid_len: got %0d cycles required 1", n_vcyc - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL single_ferr: got %0d pulses required 0", n_ferr - f0); end
    checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL single_ovr: got %0d pulses required 0", n_ovr - o0); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_vcyc; f0 = n_ferr;
    serial_in = 1'b0;
    wait_cyc(1);
    serial_in = 1'b1;
    wait_cyc(20);
    checks++; if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d cycles required 0", n_vcyc - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses required 0", n_ferr - f0); end
    checks++; if (dut.state_q !== S_IDLE) begin errors++; $display("FAIL glitch_state: got %0d required %0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_frame_error();
    int v0, f0, h0;
    v0 = n_vcyc; f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cyc(100);
    serial_in = 1'b1;
    wait_cyc(10);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d required 1", n_ferr - f0); end
    checks++; if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d cycles required 0", n_vcyc - v0); end
    h0 = n_hs;
    send_frame(8'h56, 1'b1, 1'b1);
    wait_cyc(10);
    checks++; if (n_hs - h0 !== 1) begin errors++; $display("FAIL ferr_recover: got %0d bytes required 1", n_hs - h0); end
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_after: got %0d pulses required 1", n_ferr - f0); end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = n_ovr;
    data_out_ready = 1'b0;
    send_frame(8'h62, 1'b1, 1'b1);
    wait_cyc(3);
    send_frame(8'h63, 1'b1, 1'b0);
    wait_cyc(10);
    checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b required 1", data_out_valid); end
    checks++; if (data_out !== 8'h62) begin errors++; $display("FAIL ovr_data: got %h required 62", data_out); end
    checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d required 1", n_ovr - o0); end
    data_out_ready = 1'b1;
    wait_cyc(1);
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop: valid got %b required 0", data_out_valid); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL ovr_pending: got %0d queued required 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back();
    int h0, f0;
    h0 = n_hs; f0 = n_ferr;
    data_out_ready = 1'b1;
    send_frame(8'h63, 1'b1, 1'b1);
    send_frame(8'h64, 1'b1, 1'b1);
    wait_cyc(10);
    checks++; if (n_hs - h0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d bytes required 2", n_hs - h0); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d queued required 0", sb_q.size()); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d pulses required 0", n_ferr - f0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int v0, f0, h0;
    b = 8'h20;
    data_out_ready = 1'b1;
    serial_in = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      serial_in = b[i];
      wait_cyc(BIT_CYC);
    end
    serial_in = b[3];
    wait_cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h required 00", data_out); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b required 0", data_out_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr: got %b required 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_ovr: got %b required 0", overrun); end
    wait_cyc(3);
    serial_in = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    v0 = n_vcyc; f0 = n_ferr;
    wait_cyc(30);
    checks++; if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL mid_rst_spurious: got %0d valid cycles required 0", n_vcyc - v0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL mid_rst_spur_ferr: got %0d pulses required 0", n_ferr - f0); end
    h0 = n_hs;
    send_frame(8'h31, 1'b1, 1'b1);
    wait_cyc(10);
    checks++; if (n_hs - h0 !== 1) begin errors++; $display("FAIL mid_rst_recover: got %0d bytes required 1", n_hs - h0); end
    checks++; if (data_out !== 8'h31) begin errors++; $display("FAIL mid_rst_data_after: got %h required 31", data_out); end
  endtask

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL final_pending: got %0d queued required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
